// File: rtl/block_tokenizer.sv
// block_tokenizer: splits a byte stream into words, classifies BEGIN/END/OTHER and queues tokens
// Defining BLOCK_TOKENIZER_WS_SEP_EN makes tab, LF and CR separators alongside space.
module block_tokenizer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in,
  input  logic             eos,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [1:0]       tok_type,
  output logic [LEN_W-1:0] tok_len,
  output logic [15:0]      word_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER} state_t;
  state_t st, st_nx;
  logic [LEN_W-1:0] len, len_nx, push_len;
  logic [1:0] push_type;
  logic push, pop, accept, is_sep;
  logic [7:0] c;
  logic [LEN_W+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  function automatic logic [1:0] kind(input state_t s);
    return s == S_BEGIN ? 2'b01 : s == S_END ? 2'b10 : 2'b00;
  endfunction
`ifdef BLOCK_TOKENIZER_WS_SEP_EN
  assign is_sep = in == 8'h20 || in == 8'h09 || in == 8'h0a || in == 8'h0d;
`else
  assign is_sep = in == 8'h20;
`endif
  assign c = (in >= "A" && in <= "Z") ? (in | 8'h20) : in;
  assign in_ready = cnt != (AW+1)'(FIFO_DEPTH);
  assign tok_valid = cnt != '0;
  assign accept = in_valid && in_ready;
  assign pop = tok_valid && tok_ready;
  assign tok_type = tok_valid ? mem[rp][LEN_W+1:LEN_W] : 2'b00;
  assign tok_len = tok_valid ? mem[rp][LEN_W-1:0] : '0;
  always_comb begin
    st_nx = st;
    len_nx = len;
    push = 1'b0;
    push_type = 2'b00;
    push_len = len;
    if (accept && is_sep) begin
      st_nx = S_IDLE;
      len_nx = '0;
      push = st != S_IDLE;
      push_type = kind(st);
    end else if (accept) begin
      case (st)
        S_IDLE:  st_nx = c == "b" ? S_B : c == "e" ? S_E : S_OTHER;
        S_B:     st_nx = c == "e" ? S_BE : S_OTHER;
        S_BE:    st_nx = c == "g" ? S_BEG : S_OTHER;
        S_BEG:   st_nx = c == "i" ? S_BEGI : S_OTHER;
        S_BEGI:  st_nx = c == "n" ? S_BEGIN : S_OTHER;
        S_E:     st_nx = c == "n" ? S_EN : S_OTHER;
        S_EN:    st_nx = c == "d" ? S_END : S_OTHER;
        default: st_nx = S_OTHER;
      endcase
      len_nx = len == '1 ? len : len + 1'b1;
      // eos closes the word that includes this byte
      if (eos) begin
        push = 1'b1;
        push_type = kind(st_nx);
        push_len = len_nx;
        st_nx = S_IDLE;
        len_nx = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_IDLE;
      len <= '0;
      word_count <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      st <= st_nx;
      len <= len_nx;
      if (push) word_count <= word_count + 16'd1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {push_type, push_len};
endmodule

// File: tb/tb_block_tokenizer.sv
// tb_block_tokenizer: directed streams checked against a word-level token model every cycle
module tb_block_tokenizer;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0, in_valid = 0, eos = 0, tok_ready = 0;
  logic [7:0] in = 0;
  logic in_ready, tok_valid;
  logic [1:0] tok_type;
  logic [7:0] tok_len;
  logic [15:0] word_count;
  int total = 0, bad = 0;
  logic [9:0] mq[$];
  logic [9:0] seen[$];
  logic [7:0] w[$];
  int mwc = 0;

  block_tokenizer #(.FIFO_DEPTH(DEPTH), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in), .eos(eos),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_len(tok_len),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic bit is_sep(input logic [7:0] b);
`ifdef BLOCK_TOKENIZER_WS_SEP_EN
    return b == 8'h20 || b == 8'h09 || b == 8'h0a || b == 8'h0d;
`else
    return b == 8'h20;
`endif
  endfunction

  function automatic logic [9:0] word_token();
    int n = w.size();
    logic [1:0] t = 2'b00;
    if (n == 5 && {w[0], w[1], w[2], w[3], w[4]} == "begin") t = 2'b01;
    if (n == 3 && {w[0], w[1], w[2]} == "end") t = 2'b10;
    return {t, n > 255 ? 8'd255 : 8'(n)};
  endfunction

  task automatic emit();
    mq.push_back(word_token());
    w.delete();
    mwc = (mwc + 1) % 65536;
  endtask

  // word-level reference: a byte is taken when the queue has room before this edge's pop
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      w.delete();
      mwc = 0;
    end else begin
      logic acc;
      acc = in_valid && mq.size() < DEPTH;
      if (tok_ready && mq.size() > 0) begin
        seen.push_back({tok_type, tok_len});
        void'(mq.pop_front());
      end
      if (acc) begin
        if (is_sep(in)) begin
          if (w.size() > 0) emit();
        end else begin
          w.push_back((in >= "A" && in <= "Z") ? in + 8'd32 : in);
          if (eos) emit();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("tok_valid", tok_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("tok_type", tok_type, mq[0][9:8]);
        chk("tok_len", tok_len, mq[0][7:0]);
      end
      chk("word_count", word_count, mwc);
    end
  end

  task automatic send(input logic [7:0] b, input logic e);
    int n = 0;
    logic ok;
    in_valid = 1;
    in = b;
    eos = e;
    forever begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (ok) break;
      if (++n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    in_valid = 0;
    eos = 0;
  endtask

  task automatic send_str(input string s, input logic eos_last);
    for (int i = 0; i < s.len(); i++) send(s[i], eos_last && i == s.len() - 1);
  endtask

  task automatic drain();
    int n = 0;
    tok_ready = 1;
    while (tok_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", tok_valid, 0);
    tok_ready = 0;
  endtask

  task automatic expect_tok(input string n, input int idx, input int t, input int l);
    if (idx >= seen.size()) chk({n, "_missing"}, seen.size(), idx + 1);
    else begin
      chk({n, "_type"}, seen[idx][9:8], t);
      chk({n, "_len"}, seen[idx][7:0], l);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tok_valid", tok_valid, 0);
    chk("rst_tok_type", tok_type, 0);
    chk("rst_tok_len", tok_len, 0);
    chk("rst_word_count", word_count, 0);
    reset = 1;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    tok_ready = 1;
    seen.delete();
    send_str("Begin end ", 0);
    drain();
    chk("t1_count", seen.size(), 2);
    expect_tok("t1_a", 0, 1, 5);
    expect_tok("t1_b", 1, 2, 3);
    chk("t1_wc", word_count, 2);

    seen.delete();
    tok_ready = 1;
    send_str("  beginx  en  END", 1);
    drain();
    chk("t2_count", seen.size(), 3);
    expect_tok("t2_a", 0, 0, 6);
    expect_tok("t2_b", 1, 0, 2);
    expect_tok("t2_c", 2, 2, 3);
    chk("t2_wc", word_count, 5);

    seen.delete();
    tok_ready = 0;
    send_str("a b c d ", 0);
    chk("t3_full_ready", in_ready, 0);
    in_valid = 1;
    in = "e";
    repeat (3) @(negedge clk);
    chk("t3_frozen_wc", word_count, 9);
    chk("t3_still_full", in_ready, 0);
    in_valid = 0;
    tok_ready = 1;
    @(negedge clk);
    tok_ready = 0;
    chk("t3_ready_after_pop", in_ready, 1);
    send_str("e ", 0);
    drain();
    chk("t3_count", seen.size(), 5);
    expect_tok("t3_fifth", 4, 0, 1);

    seen.delete();
    tok_ready = 1;
    for (int i = 0; i < 300; i++) send("x", 0);
    send(" ", 0);
    drain();
    chk("t4_count", seen.size(), 1);
    expect_tok("t4_sat", 0, 0, 255);

    seen.delete();
    send_str("beg", 0);
    reset = 0;
    #1;
    chk("t5_tok_valid", tok_valid, 0);
    chk("t5_wc", word_count, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    send_str("in ", 0);
    drain();
    chk("t5_count", seen.size(), 1);
    expect_tok("t5_tok", 0, 0, 2);
    chk("t5_wc_after", word_count, 1);

    seen.delete();
    send_str("end\tbegin\n", 1);
    drain();
`ifdef BLOCK_TOKENIZER_WS_SEP_EN
    chk("t6_count", seen.size(), 2);
    expect_tok("t6_a", 0, 2, 3);
    expect_tok("t6_b", 1, 1, 5);
`else
    chk("t6_count", seen.size(), 1);
    expect_tok("t6_a", 0, 0, 10);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
